// File: rtl/mdu_seq.sv
// ---------------------------------------------------------------------------
// mdu_seq -- iterative unsigned multiply / divide sequencer
//
// Performs a WIDTH x WIDTH unsigned multiply (2*WIDTH-bit product) or an
// unsigned restoring divide (quotient + remainder) in WIDTH iterations.
// All iterations go through a single shared WIDTH+1-bit adder.
//
// Ports:
//   clk      in   1      rising-edge clock
//   rst      in   1      asynchronous active-high reset
//   start    in   1      begin an operation (accepted in IDLE or DONE)
//   op       in   1      0 = MUL, 1 = DIV, sampled with start
//   x        in   WIDTH  multiplicand / dividend, sampled with start
//   y        in   WIDTH  multiplier / divisor, sampled with start
//   flush    in   1      synchronous abort; overrides start
//   busy     out  1      high while iterating
//   done     out  1      one-cycle pulse when results become valid
//   result   out  WIDTH  low product / quotient
//   result2  out  WIDTH  high product / remainder
// ---------------------------------------------------------------------------
module mdu_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] result2
);

   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic [WIDTH-1:0] opd;
   logic             op_q;

   logic [WIDTH-1:0] div_r;
   logic [WIDTH-1:0] add_a;
   logic [WIDTH-1:0] add_b;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] hi_nxt;
   logic [WIDTH-1:0] lo_nxt;

   // One shared adder. For DIV it computes r - opd as r + ~opd + 1, so the
   // carry out of bit WIDTH is the inverted borrow.
   always_comb begin
      div_r  = {hi[WIDTH-2:0], lo[WIDTH-1]};
      add_a  = op_q ? div_r : hi;
      add_b  = op_q ? ~opd : (lo[0] ? opd : '0);
      sum    = {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, op_q};
      hi_nxt = hi;
      lo_nxt = lo;
      if (op_q) begin
         if (sum[WIDTH]) begin
            hi_nxt = sum[WIDTH-1:0];
            lo_nxt = {lo[WIDTH-2:0], 1'b1};
         end else begin
            hi_nxt = div_r;
            lo_nxt = {lo[WIDTH-2:0], 1'b0};
         end
      end else begin
         {hi_nxt, lo_nxt} = {sum, lo[WIDTH-1:1]};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         hi    <= '0;
         lo    <= '0;
         opd   <= '0;
         op_q  <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start && !flush) begin
                  op_q  <= op;
                  hi    <= '0;
                  lo    <= op ? x : y;
                  opd   <= op ? y : x;
                  cnt   <= CW'(WIDTH);
                  state <= RUN;
               end else begin
                  state <= IDLE;
               end
            end
            RUN: begin
               // Abort leaves hi/lo holding partial values; they are only
               // meaningful again after the next completed operation.
               if (flush) begin
                  state <= IDLE;
               end else begin
                  hi  <= hi_nxt;
                  lo  <= lo_nxt;
                  cnt <= cnt - CW'(1);
                  if (cnt == CW'(1)) state <= DONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Decodes of the state register only; no path from the inputs.
   assign busy    = (state == RUN);
   assign done    = (state == DONE);
   assign result  = lo;
   assign result2 = hi;

endmodule
